audio_clk_gen: RTL and testbench

- Parametrised fractional-N audio clock-enable generator, successor to the fixed single-output audio PLL wrapper.
- Derives an MCLK tick stream, plus BCLK and LRCK levels, from refclk using a phase accumulator.
- Supports four runtime-selectable sample-rate increments and a lock indicator with settling count.
- Sits between the board reference clock and the I2S/codec serializer; all outputs are synchronous to refclk.

---
 rtl/audio_clk_gen.sv | 182 ++++++++++++++++++
 tb/tb_audio_clk_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_clk_gen.sv
// audio_clk_gen: fractional-N audio clock-enable generator.
// A phase accumulator clocked by refclk produces an MCLK tick stream whose
// average rate is INC/2^ACC_W of refclk. BCLK and LRCK levels are divided down
// from the ticks. A settle counter gates the locked indicator after reset or
// after any change of the selected rate.
module audio_clk_gen #(
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned INC0       = 6184753,
    parameter int unsigned INC1       = 5662316,
    parameter int unsigned INC2       = 4106424,
    parameter int unsigned INC3       = 3078636,
    parameter int unsigned BCLK_HALF  = 4,
    parameter int unsigned SLOT_BITS  = 32,
    parameter int unsigned LOCK_TICKS = 256
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic [1:0] rate_sel,
    output logic       mclk_tick,
    output logic       bclk,
    output logic       bclk_fall,
    output logic       lrck,
    output logic       locked
);

    // Counter widths; a divide-by-one still needs a one-bit counter.
    localparam int BCW = (BCLK_HALF  > 1) ? $clog2(BCLK_HALF)  : 1;
    localparam int SBW = (SLOT_BITS  > 1) ? $clog2(SLOT_BITS)  : 1;
    localparam int LCW = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;

    localparam logic [BCW-1:0] BCLK_LAST = BCW'(BCLK_HALF - 1);
    localparam logic [SBW-1:0] SLOT_LAST = SBW'(SLOT_BITS - 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TICKS - 1);

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rate_q;
    logic [ACC_W-1:0] acc_q;
    logic             mclk_tick_q;
    logic [BCW-1:0]   bclk_cnt_q;
    logic             bclk_q;
    logic             bclk_fall_q;
    logic [SBW-1:0]   bit_cnt_q;
    logic             lrck_q;
    logic [LCW-1:0]   lock_cnt_q;

    logic [ACC_W-1:0] inc_sel;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             rate_chg;
    logic             bclk_term;
    logic             bclk_fall_d;
    logic             slot_term;
    logic             lock_done;

    // Increment for the currently registered rate; a new selection only
    // takes effect once rate_q has been updated.
    always_comb begin
        inc_sel = ACC_W'(INC0);
        case (rate_q)
            2'd0:    inc_sel = ACC_W'(INC0);
            2'd1:    inc_sel = ACC_W'(INC1);
            2'd2:    inc_sel = ACC_W'(INC2);
            default: inc_sel = ACC_W'(INC3);
        endcase
    end

    // One extra bit keeps the carry; the residue stays in the low bits so
    // the long-run tick rate is exact.
    assign sum      = {1'b0, acc_q} + {1'b0, inc_sel};
    assign carry    = sum[ACC_W];
    assign rate_chg = (rate_sel != rate_q);

    // Divider terminal counts, all qualified by this cycle's carry.
    assign bclk_term   = carry && (bclk_cnt_q == BCLK_LAST);
    assign bclk_fall_d = bclk_term && bclk_q;
    assign slot_term   = bclk_fall_d && (bit_cnt_q == SLOT_LAST);
    assign lock_done   = (state_q == SETTLE) && carry && (lock_cnt_q == LOCK_LAST);

    // Lock FSM next state; a rate change always returns to SETTLE.
    always_comb begin
        state_d = state_q;
        if (rate_chg) begin
            state_d = SETTLE;
        end else begin
            case (state_q)
                SETTLE:  if (lock_done) state_d = LOCKED;
                LOCKED:  state_d = LOCKED;
                default: state_d = SETTLE;
            endcase
        end
    end

    // Lock FSM state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Rate register and phase accumulator; a rate change clears the
    // accumulator and suppresses any carry produced on the same edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            rate_q      <= rate_sel;
            acc_q       <= '0;
            mclk_tick_q <= 1'b0;
        end else if (rate_chg) begin
            rate_q      <= rate_sel;
            acc_q       <= '0;
            mclk_tick_q <= 1'b0;
        end else begin
            acc_q       <= sum[ACC_W-1:0];
            mclk_tick_q <= carry;
        end
    end

    // BCLK divider: toggles every BCLK_HALF ticks, flags the falling edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            bclk_cnt_q  <= '0;
            bclk_q      <= 1'b0;
            bclk_fall_q <= 1'b0;
        end else if (rate_chg) begin
            bclk_cnt_q  <= '0;
            bclk_q      <= 1'b0;
            bclk_fall_q <= 1'b0;
        end else begin
            bclk_fall_q <= bclk_fall_d;
            if (carry) begin
                if (bclk_term) begin
                    bclk_cnt_q <= '0;
                    bclk_q     <= ~bclk_q;
                end else begin
                    bclk_cnt_q <= bclk_cnt_q + 1'b1;
                end
            end
        end
    end

    // LRCK divider: counts BCLK falling edges, toggles with the last one.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
        end else if (rate_chg) begin
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
        end else if (bclk_fall_d) begin
            if (slot_term) begin
                bit_cnt_q <= '0;
                lrck_q    <= ~lrck_q;
            end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // Settle counter: counts ticks while settling and freezes once locked.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_cnt_q <= '0;
        end else if (rate_chg) begin
            lock_cnt_q <= '0;
        end else if ((state_q == SETTLE) && carry && !lock_done) begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
        end
    end

    assign mclk_tick = mclk_tick_q;
    assign bclk      = bclk_q;
    assign bclk_fall = bclk_fall_q;
    assign lrck      = lrck_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_audio_clk_gen.sv
// Bench for audio_clk_gen with a small configuration (ACC_W=4, INC 4/3/0/8,
// BCLK_HALF=2, SLOT_BITS=2, LOCK_TICKS=3). Stimulus pushes the edge numbers at
// which each output event is due; a negedge monitor pops and compares them.
module tb_audio_clk_gen;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rate_sel = 2'd0;
    logic       mclk_tick, bclk, bclk_fall, lrck, locked;

    audio_clk_gen #(
        .ACC_W(4), .INC0(4), .INC1(3), .INC2(0), .INC3(8),
        .BCLK_HALF(2), .SLOT_BITS(2), .LOCK_TICKS(3)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .rate_sel (rate_sel),
        .mclk_tick(mclk_tick),
        .bclk     (bclk),
        .bclk_fall(bclk_fall),
        .lrck     (lrck),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    int edge_n = 0;
    always @(posedge refclk) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;
    int tick_q[$];
    int fall_q[$];
    int lrck_q[$];
    int lock_q[$];
    logic prev_lrck = 1'b0;
    logic prev_locked = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: every observed event must match the next expected edge number.
    always @(negedge refclk) begin
        if (!rst) begin
            if (mclk_tick) begin
                if (tick_q.size() == 0) chk("tick_unexpected", edge_n, -1);
                else chk("tick_edge", edge_n, tick_q.pop_front());
            end
            if (bclk_fall) begin
                if (fall_q.size() == 0) chk("bclk_fall_unexpected", edge_n, -1);
                else chk("bclk_fall_edge", edge_n, fall_q.pop_front());
            end
            if (lrck != prev_lrck) begin
                if (lrck_q.size() == 0) chk("lrck_unexpected", edge_n, -1);
                else chk("lrck_edge", edge_n, lrck_q.pop_front());
            end
            if (locked != prev_locked) begin
                if (lock_q.size() == 0) chk("locked_unexpected", edge_n, -1);
                else chk("locked_edge", edge_n, lock_q.pop_front());
            end
        end
        prev_lrck   <= lrck;
        prev_locked <= locked;
    end

    // Returns just after the negedge that follows edge n.
    task automatic wait_to(input int n);
        while (edge_n < n) @(negedge refclk);
        #1;
    endtask

    task automatic drained(input string tag);
        chk({tag, "_ticks_left"}, tick_q.size(), 0);
        chk({tag, "_falls_left"}, fall_q.size(), 0);
        chk({tag, "_lrck_left"},  lrck_q.size(), 0);
        chk({tag, "_lock_left"},  lock_q.size(), 0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_mclk_tick"}, mclk_tick, 0);
        chk({tag, "_bclk"},      bclk, 0);
        chk({tag, "_bclk_fall"}, bclk_fall, 0);
        chk({tag, "_lrck"},      lrck, 0);
        chk({tag, "_locked"},    locked, 0);
    endtask

    // Scenario-1 event list relative to the first edge after reset release.
    task automatic push_startup(input int base, input int last);
        for (int k = 4; k <= last; k += 4) tick_q.push_back(base + k);
        for (int k = 16; k <= last; k += 16) fall_q.push_back(base + k);
        for (int k = 32; k <= last; k += 32) lrck_q.push_back(base + k);
        lock_q.push_back(base + 12);
    endtask

    initial begin
        int base, e, f, g, h, j;
        int inc3_ticks[9];
        inc3_ticks = '{6, 11, 16, 22, 27, 32, 38, 43, 48};

        // Reset state.
        repeat (3) @(negedge refclk);
        #1;
        chk_cleared("reset");

        // Startup at rate 0: tick every 4, bclk period 16, lrck period 64.
        rst = 1'b0;
        base = edge_n;
        push_startup(base, 106);
        wait_to(base + 106);
        chk("pre_chg1_bclk", bclk, 1);
        chk("pre_chg1_lrck", lrck, 1);
        chk("pre_chg1_locked", locked, 1);
        drained("startup");

        // Mid-frame switch to rate 1 (INC=3): spacing 6,5,5.
        e = base + 107;
        rate_sel = 2'd1;
        lrck_q.push_back(e);
        lock_q.push_back(e);
        foreach (inc3_ticks[i]) tick_q.push_back(e + inc3_ticks[i]);
        fall_q.push_back(e + 22);
        fall_q.push_back(e + 43);
        lrck_q.push_back(e + 43);
        lock_q.push_back(e + 16);
        wait_to(e);
        chk_cleared("chg1");
        wait_to(e + 50);
        chk("rate1_locked", locked, 1);
        chk("rate1_lrck", lrck, 1);
        drained("rate1");

        // Back to rate 0, then change exactly on the lock-completion edge.
        f = e + 51;
        rate_sel = 2'd0;
        lrck_q.push_back(f);
        lock_q.push_back(f);
        tick_q.push_back(f + 4);
        tick_q.push_back(f + 8);
        wait_to(f + 11);
        chk("pre_chg3_bclk", bclk, 1);
        chk("pre_chg3_locked", locked, 0);
        drained("pre_chg3");
        g = f + 12;
        rate_sel = 2'd2;
        wait_to(g);
        chk_cleared("chg3_lock_collision");

        // INC=0: no ticks and no lock, ever.
        wait_to(g + 40);
        chk("inc0_locked", locked, 0);
        drained("inc0");

        // Rate 0 again, then change on the bclk terminal count (bclk high).
        h = g + 41;
        rate_sel = 2'd0;
        tick_q.push_back(h + 4);
        tick_q.push_back(h + 8);
        tick_q.push_back(h + 12);
        lock_q.push_back(h + 12);
        j = h + 16;
        lock_q.push_back(j);
        wait_to(h + 15);
        chk("pre_chg4_bclk", bclk, 1);
        chk("pre_chg4_locked", locked, 1);
        rate_sel = 2'd3;
        wait_to(j);
        chk_cleared("chg4_bclk_collision");

        // Rate 3 (INC=8): tick every 2, lock on the 3rd tick.
        for (int k = 2; k <= 8; k += 2) tick_q.push_back(j + k);
        fall_q.push_back(j + 8);
        lock_q.push_back(j + 6);
        lock_q.push_back(j + 9);
        wait_to(j + 8);
        chk("rate3_locked", locked, 1);

        // Short asynchronous reset pulse between edges while locked.
        @(posedge refclk);
        #2;
        rate_sel = 2'd0;
        rst = 1'b1;
        #1;
        chk_cleared("async_rst");
        rst = 1'b0;
        base = edge_n;
        push_startup(base, 36);
        wait_to(base + 36);
        chk("restart_locked", locked, 1);
        drained("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
